bfly2_twiddle_mul: RTL and testbench
====================================

// Module: bfly2_twiddle_mul
// PURPOSE
// - Stage directly downstream of the 16-lane radix-2 butterfly (bfly2).
// - Takes its WIDTH+1-bit complex outputs, 16 lanes per beat.
// - Multiplies each lane by a twiddle factor read from an external 1-cycle-latency ROM.
// - Rounds, saturates and emits the product with a valid flag.
// - A block counter walks the ROM through each frame of NBLK beats.
// PARAMETERS
// - WIDTH   10  bfly2 input width (SIG+INT+FLT); data in/out here is WIDTH+1 bits
// - TW_W    9   twiddle width, signed 2.7 format; +1.0 = 128
// - TW_FLT  7   twiddle fractional bits; this is the product right-shift amount
// - NBLK    4   beats per frame; twiddle set index wraps at NBLK-1
// - AW      $clog2(NBLK) tw_addr width (derived)
// PORTS
// - clk       in   1             clock, rising edge
// - rst       in   1             synchronous reset, active-high
// - valid_in  in   1             din_* beat valid
// - sof_in    in   1             first beat of frame; qualified by valid_in
// - din_re    in   [WIDTH:0]x16  signed real part (bfly2 dout)
// - din_im    in   [WIDTH:0]x16  signed imaginary part
// - tw_addr   out  AW            ROM address = twiddle set index of the accepted beat
// - tw_re     in   [TW_W-1:0]x16 ROM data, valid the cycle after tw_addr
// - tw_im     in   [TW_W-1:0]x16 ROM data, imaginary part
// - valid_out out  1             dout_* valid
// - dout_re   out  [WIDTH:0]x16  rounded, saturated real product
// - dout_im   out  [WIDTH:0]x16  rounded, saturated imaginary product
// - sat_flag  out  1             sticky saturation flag; only with BFLY_TW_SATFLAG_EN
// BEHAVIOUR
// - Reset values: blk_cnt=0, tw_addr=0, all pipe valids=0, valid_out=0, dout_*=0, sat_flag=0.
// - Pipeline, fixed latency 3 cycles valid_in->valid_out. No backpressure; one beat per cycle.
// - S0 (accept): register din_*. tw_addr = (sof_in ? 0 : blk_cnt) combinationally, so the ROM sees it this cycle.
// - S1 (multiply): tw_* now valid.
//   - p_re = d_re*w_re - d_im*w_im; p_im = d_re*w_im + d_im*w_re.
//   - Full width WIDTH+1+TW_W+1 bits, signed.
// - S2 (round/saturate):
//   - r = (p + 2^(TW_FLT-1)) >>> TW_FLT (round half toward +inf).
//   - Clamp to [-2^WIDTH, 2^WIDTH-1]; register to dout_*.
// - Block counter, on valid_in only:
//   - sof_in=1: beat uses set 0; blk_cnt<=1.
//   - Otherwise: blk_cnt<=blk_cnt+1, wrapping NBLK-1 -> 0.
//   - valid_in=0: counter holds; tw_addr still shows blk_cnt.
//   - sof_in with valid_in=0: ignored.
// - Idle cycles: pipe valid bits propagate 0; dout_* hold their last value.
// - Reset mid-operation clears in-flight beats (no valid_out afterwards) and the counter.
// - Lanes are fully independent; lane i uses tw_*[i].
// CONFIGURATION
// - BFLY_TW_SATFLAG_EN defined:
//   - sat_flag <= 1 whenever any lane re/im clamps on a valid S2 beat.
//   - Sticky until rst or a valid sof_in beat is accepted; that beat's own saturation still sets it 3 cycles later.
// - BFLY_TW_SATFLAG_EN undefined: sat_flag port absent, no flag logic; datapath identical.
// TESTING (WIDTH=10, TW_W=9, TW_FLT=7, NBLK=4)
// - Unity: all lanes din=(100,-37), tw=(128,0), one valid beat -> valid_out exactly 3 cycles later, dout=(100,-37).
// - -j rotation: din=(50,20), tw=(0,-128) -> dout=(20,-50).
// - Rounding: din=(1,0), tw=(64,0) -> dout_re=1; din=(-1,0), tw=(64,0) -> dout_re=0.
// - Saturation: din=(1023,1023), tw=(128,-128) -> dout=(1023,0).
//   - With BFLY_TW_SATFLAG_EN, sat_flag=1 until the next sof beat.
// - Counter/wrap: sof then 5 back-to-back beats -> tw_addr 0,1,2,3,0.
//   - valid gap mid-frame holds tw_addr.
//   - sof on 3rd beat forces tw_addr=0, then 1.
// - Reset: assert rst one cycle while 2 beats are in flight -> no valid_out afterwards.
//   - tw_addr=0, dout=0, sat_flag=0.

Source files
------------

// File: rtl/bfly2_twiddle_mul.sv
`default_nettype none
// ============================================================================
// Module   : bfly2_twiddle_mul
// Purpose  : 16-lane complex twiddle multiply behind bfly2, 3-cycle pipeline
//            with round-half-up and saturation. Optional sticky sat_flag
//            port when BFLY_TW_SATFLAG_EN is defined.
// Revision : 1.0
// ============================================================================
module bfly2_twiddle_mul #(
    parameter int WIDTH  = 10,
    parameter int TW_W   = 9,
    parameter int TW_FLT = 7,
    parameter int NBLK   = 4,
    parameter int AW     = $clog2(NBLK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  sof_in,
    input  logic [15:0][WIDTH:0]  din_re,
    input  logic [15:0][WIDTH:0]  din_im,
    output logic [AW-1:0]         tw_addr,
    input  logic [15:0][TW_W-1:0] tw_re,
    input  logic [15:0][TW_W-1:0] tw_im,
    output logic                  valid_out,
    output logic [15:0][WIDTH:0]  dout_re,
    output logic [15:0][WIDTH:0]  dout_im
`ifdef BFLY_TW_SATFLAG_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int C_LANES = 16;
    localparam int C_PW    = WIDTH + 1 + TW_W + 1;
    localparam logic signed [C_PW-1:0] C_MAX  = C_PW'((2 ** WIDTH) - 1);
    localparam logic signed [C_PW-1:0] C_MIN  = C_PW'(-(2 ** WIDTH));
    localparam logic signed [C_PW-1:0] C_HALF = C_PW'(2 ** (TW_FLT - 1));

    logic [AW-1:0]                r_blk_cnt;
    logic [AW-1:0]                w_addr;
    logic                         r_v1;
    logic                         r_v2;
    logic [15:0][WIDTH:0]         r_d_re;
    logic [15:0][WIDTH:0]         r_d_im;
    logic [15:0][C_PW-1:0]        r_p_re;
    logic [15:0][C_PW-1:0]        r_p_im;
    logic [15:0][C_PW-1:0]        w_p_re;
    logic [15:0][C_PW-1:0]        w_p_im;
    logic [15:0][WIDTH:0]         w_q_re;
    logic [15:0][WIDTH:0]         w_q_im;
`ifdef BFLY_TW_SATFLAG_EN
    logic [2*C_LANES-1:0]         w_sat;
`endif

    // A qualified sof restarts the frame at twiddle set 0 in the same cycle.
    assign w_addr  = (valid_in && sof_in) ? '0 : r_blk_cnt;
    assign tw_addr = w_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (valid_in) begin
            r_blk_cnt <= (w_addr == AW'(NBLK - 1)) ? '0 : w_addr + AW'(1);
        end
    end

    generate
        for (genvar i = 0; i < C_LANES; i++) begin : g_lane
            logic signed [C_PW-1:0] w_dre;
            logic signed [C_PW-1:0] w_dim;
            logic signed [C_PW-1:0] w_wre;
            logic signed [C_PW-1:0] w_wim;
            logic signed [C_PW-1:0] w_sre;
            logic signed [C_PW-1:0] w_sim;
            logic signed [C_PW-1:0] w_rre;
            logic signed [C_PW-1:0] w_rim;

            assign w_dre = C_PW'($signed(r_d_re[i]));
            assign w_dim = C_PW'($signed(r_d_im[i]));
            assign w_wre = C_PW'($signed(tw_re[i]));
            assign w_wim = C_PW'($signed(tw_im[i]));

            assign w_p_re[i] = w_dre * w_wre - w_dim * w_wim;
            assign w_p_im[i] = w_dre * w_wim + w_dim * w_wre;

            assign w_sre = $signed(r_p_re[i]) + C_HALF;
            assign w_sim = $signed(r_p_im[i]) + C_HALF;
            assign w_rre = w_sre >>> TW_FLT;
            assign w_rim = w_sim >>> TW_FLT;

            assign w_q_re[i] = (w_rre > C_MAX) ? C_MAX[WIDTH:0] :
                               (w_rre < C_MIN) ? C_MIN[WIDTH:0] : w_rre[WIDTH:0];
            assign w_q_im[i] = (w_rim > C_MAX) ? C_MAX[WIDTH:0] :
                               (w_rim < C_MIN) ? C_MIN[WIDTH:0] : w_rim[WIDTH:0];
`ifdef BFLY_TW_SATFLAG_EN
            assign w_sat[2*i]   = (w_rre > C_MAX) || (w_rre < C_MIN);
            assign w_sat[2*i+1] = (w_rim > C_MAX) || (w_rim < C_MIN);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            valid_out <= 1'b0;
            r_d_re    <= '0;
            r_d_im    <= '0;
            r_p_re    <= '0;
            r_p_im    <= '0;
            dout_re   <= '0;
            dout_im   <= '0;
        end else begin
            r_v1      <= valid_in;
            r_v2      <= r_v1;
            valid_out <= r_v2;
            if (valid_in) begin
                r_d_re <= din_re;
                r_d_im <= din_im;
            end
            if (r_v1) begin
                r_p_re <= w_p_re;
                r_p_im <= w_p_im;
            end
            // Outputs hold their last value across idle cycles.
            if (r_v2) begin
                dout_re <= w_q_re;
                dout_im <= w_q_im;
            end
        end
    end

`ifdef BFLY_TW_SATFLAG_EN
    // A clamp on an emerging beat outranks a same-cycle sof clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (r_v2 && (|w_sat)) begin
            sat_flag <= 1'b1;
        end else if (valid_in && sof_in) begin
            sat_flag <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bfly2_twiddle_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly2_twiddle_mul
// Purpose  : Self-checking bench for bfly2_twiddle_mul: directed cases plus
//            randomized beats against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_bfly2_twiddle_mul;

    localparam int WIDTH  = 10;
    localparam int TW_W   = 9;
    localparam int TW_FLT = 7;
    localparam int NBLK   = 4;
    localparam int AW     = 2;
    localparam int L      = 16;
    localparam int DW     = WIDTH + 1;

    typedef logic [L-1:0][31:0] lanes_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  valid_in;
    logic                  sof_in;
    logic [L-1:0][WIDTH:0] din_re;
    logic [L-1:0][WIDTH:0] din_im;
    logic [AW-1:0]         tw_addr;
    logic [L-1:0][TW_W-1:0] tw_re;
    logic [L-1:0][TW_W-1:0] tw_im;
    logic                  valid_out;
    logic [L-1:0][WIDTH:0] dout_re;
    logic [L-1:0][WIDTH:0] dout_im;
`ifdef BFLY_TW_SATFLAG_EN
    logic                  sat_flag;
`endif

    always #5 clk = ~clk;

    bfly2_twiddle_mul #(
        .WIDTH (WIDTH),
        .TW_W  (TW_W),
        .TW_FLT(TW_FLT),
        .NBLK  (NBLK),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .sof_in   (sof_in),
        .din_re   (din_re),
        .din_im   (din_im),
        .tw_addr  (tw_addr),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .valid_out(valid_out),
        .dout_re  (dout_re),
`ifdef BFLY_TW_SATFLAG_EN
        .sat_flag (sat_flag),
`endif
        .dout_im  (dout_im)
    );

    // Twiddle ROM: one-cycle read latency from tw_addr.
    int            tab_re [NBLK][L];
    int            tab_im [NBLK][L];
    logic [AW-1:0] rom_q;
    always_ff @(posedge clk) rom_q <= tw_addr;
    always_comb begin
        for (int i = 0; i < L; i++) begin
            tw_re[i] = TW_W'(tab_re[rom_q][i]);
            tw_im[i] = TW_W'(tab_im[rom_q][i]);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rnd(input int p);
        return (p + (1 <<< (TW_FLT - 1))) >>> TW_FLT;
    endfunction

    function automatic int clampv(input int r);
        if (r > (1 <<< WIDTH) - 1) return (1 <<< WIDTH) - 1;
        if (r < -(1 <<< WIDTH))    return -(1 <<< WIDTH);
        return r;
    endfunction

    // Reference model: expected beats with the cycle they must appear.
    int     cyc = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    int     q_due [$];
    lanes_t q_re [$];
    lanes_t q_im [$];
    bit     q_sat [$];
    lanes_t m_last_re;
    lanes_t m_last_im;
    lanes_t m_er;
    lanes_t m_ei;
    bit     m_s;
    int     m_a, dr, di, wr, wi, rr, ri;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q_due.delete(); q_re.delete(); q_im.delete(); q_sat.delete();
            m_cnt     = 0;
            m_sat     = 1'b0;
            m_last_re = '0;
            m_last_im = '0;
        end else begin
            if (q_due.size() > 0 && q_due[0] == cyc && q_sat[0]) m_sat = 1'b1;
            else if (valid_in && sof_in)                          m_sat = 1'b0;
            if (valid_in) begin
                m_a = sof_in ? 0 : m_cnt;
                m_s = 1'b0;
                for (int i = 0; i < L; i++) begin
                    dr = $signed(din_re[i]);
                    di = $signed(din_im[i]);
                    wr = tab_re[m_a][i];
                    wi = tab_im[m_a][i];
                    rr = rnd(dr * wr - di * wi);
                    ri = rnd(dr * wi + di * wr);
                    if (clampv(rr) != rr || clampv(ri) != ri) m_s = 1'b1;
                    m_er[i] = 32'(clampv(rr));
                    m_ei[i] = 32'(clampv(ri));
                end
                q_due.push_back(cyc + 2);
                q_re.push_back(m_er);
                q_im.push_back(m_ei);
                q_sat.push_back(m_s);
                m_cnt = (m_a + 1) % NBLK;
            end
        end
    end

    task automatic cmp_lanes(input string nm, input lanes_t er, input lanes_t ei);
        int a, e, bad_lane;
        bit bad;
        bad = 1'b0;
        bad_lane = 0;
        a = 0;
        e = 0;
        for (int i = 0; i < L; i++) begin
            if (!bad && (int'($signed(dout_re[i])) != int'(er[i]))) begin
                bad = 1'b1; bad_lane = i; a = $signed(dout_re[i]); e = er[i];
            end
            if (!bad && (int'($signed(dout_im[i])) != int'(ei[i]))) begin
                bad = 1'b1; bad_lane = i + 100; a = $signed(dout_im[i]); e = ei[i];
            end
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s cyc %0d lane %0d (>=100 is im): got %0d expected %0d",
                     nm, cyc, bad_lane, a, e);
        end
    endtask

    bit c_ev;
    always @(negedge clk) begin
        c_ev = (q_due.size() > 0) && (q_due[0] == cyc);
        n_checks++;
        if (valid_out !== c_ev) begin
            n_fail++;
            $display("FAIL valid_out cyc %0d: got %0b expected %0b", cyc, valid_out, c_ev);
        end
        if (c_ev) begin
            cmp_lanes("dout_model", q_re[0], q_im[0]);
            m_last_re = q_re[0];
            m_last_im = q_im[0];
            void'(q_due.pop_front()); void'(q_re.pop_front());
            void'(q_im.pop_front());  void'(q_sat.pop_front());
        end else begin
            cmp_lanes("dout_hold", m_last_re, m_last_im);
        end
`ifdef BFLY_TW_SATFLAG_EN
        chk("sat_flag_model", int'(sat_flag), int'(m_sat));
`endif
    end

    task automatic set_tw(input int re, input int im);
        for (int s = 0; s < NBLK; s++)
            for (int i = 0; i < L; i++) begin
                tab_re[s][i] = re;
                tab_im[s][i] = im;
            end
    endtask

    task automatic drive(input bit v, input bit s, input int re, input int im, input int ea);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = v;
        sof_in   = s;
        for (int i = 0; i < L; i++) begin
            din_re[i] = DW'(re);
            din_im[i] = DW'(im);
        end
        #1;
        chk("tw_addr_model", int'(tw_addr), (v && s) ? 0 : m_cnt);
        if (ea >= 0) chk("tw_addr_lit", int'(tw_addr), ea);
    endtask

    task automatic drive_rand();
        int mag;
        @(negedge clk);
        rst      = 1'b0;
        valid_in = ($urandom_range(0, 9) < 7);
        sof_in   = ($urandom_range(0, 7) == 0);
        mag      = ($urandom_range(0, 1) == 0) ? 255 : 1023;
        for (int i = 0; i < L; i++) begin
            din_re[i] = DW'(int'($urandom_range(0, 2 * mag + 1)) - mag - 1);
            din_im[i] = DW'(int'($urandom_range(0, 2 * mag + 1)) - mag - 1);
        end
        #1;
        chk("tw_addr_rand", int'(tw_addr), (valid_in && sof_in) ? 0 : m_cnt);
    endtask

    // Call right after a single-beat drive; checks exact 3-cycle latency.
    task automatic expect_beat(input string nm, input int re, input int im);
        drive(1'b0, 1'b0, 0, 0, -1);
        drive(1'b0, 1'b0, 0, 0, -1);
        chk({nm, "_early"}, int'(valid_out), 0);
        drive(1'b0, 1'b0, 0, 0, -1);
        chk({nm, "_valid"}, int'(valid_out), 1);
        chk({nm, "_re0"},  int'($signed(dout_re[0])),  re);
        chk({nm, "_im0"},  int'($signed(dout_im[0])),  im);
        chk({nm, "_re15"}, int'($signed(dout_re[15])), re);
        chk({nm, "_im15"}, int'($signed(dout_im[15])), im);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        din_re   = '0;
        din_im   = '0;
        set_tw(128, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tw_addr",   int'(tw_addr),   0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_dout_re",   int'($signed(dout_re[0])), 0);
`ifdef BFLY_TW_SATFLAG_EN
        chk("rst_sat_flag",  int'(sat_flag), 0);
`endif
        rst = 1'b0;

        drive(1'b1, 1'b1, 100, -37, 0);
        expect_beat("unity", 100, -37);

        set_tw(0, -128);
        drive(1'b0, 1'b0, 0, 0, -1);
        drive(1'b1, 1'b1, 50, 20, 0);
        expect_beat("rot_j", 20, -50);

        set_tw(64, 0);
        drive(1'b0, 1'b0, 0, 0, -1);
        drive(1'b1, 1'b1, 1, 0, 0);
        expect_beat("round_pos", 1, 0);
        drive(1'b1, 1'b1, -1, 0, 0);
        expect_beat("round_neg", 0, 0);

        set_tw(128, -128);
        drive(1'b0, 1'b0, 0, 0, -1);
        drive(1'b1, 1'b1, 1023, 1023, 0);
        expect_beat("sat", 1023, 0);
        drive(1'b1, 1'b0, 1, 0, 1);
        expect_beat("nosat", 1, -1);
`ifdef BFLY_TW_SATFLAG_EN
        chk("sat_sticky", int'(sat_flag), 1);
`endif
        drive(1'b1, 1'b1, 1, 0, 0);
`ifdef BFLY_TW_SATFLAG_EN
        chk("sat_before_sof_edge", int'(sat_flag), 1);
`endif
        drive(1'b0, 1'b0, 0, 0, -1);
`ifdef BFLY_TW_SATFLAG_EN
        chk("sat_cleared_by_sof", int'(sat_flag), 0);
`endif
        repeat (3) drive(1'b0, 1'b0, 0, 0, -1);

        set_tw(128, 0);
        drive(1'b1, 1'b1, 3, 4, 0);
        drive(1'b1, 1'b0, 3, 4, 1);
        drive(1'b1, 1'b0, 3, 4, 2);
        drive(1'b1, 1'b0, 3, 4, 3);
        drive(1'b1, 1'b0, 3, 4, 0);
        drive(1'b1, 1'b0, 3, 4, 1);
        drive(1'b0, 1'b0, 0, 0, 2);
        drive(1'b1, 1'b0, 3, 4, 2);
        drive(1'b1, 1'b1, 3, 4, 0);
        drive(1'b1, 1'b0, 3, 4, 1);
        drive(1'b1, 1'b1, 3, 4, 0);
        drive(1'b1, 1'b0, 3, 4, 1);
        drive(1'b0, 1'b1, 0, 0, 2);
        drive(1'b1, 1'b0, 3, 4, 2);
        repeat (3) drive(1'b0, 1'b0, 0, 0, -1);

        set_tw(128, -128);
        drive(1'b1, 1'b0, 1023, 1023, -1);
        repeat (3) drive(1'b0, 1'b0, 0, 0, -1);
        drive(1'b1, 1'b0, 5, 5, -1);
        drive(1'b1, 1'b0, 6, 6, -1);
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 0, 0, 0);
            chk("rst_flush_valid", int'(valid_out), 0);
        end
        chk("rst_mid_dout_re", int'($signed(dout_re[0])), 0);
        chk("rst_mid_dout_im", int'($signed(dout_im[5])), 0);
`ifdef BFLY_TW_SATFLAG_EN
        chk("rst_mid_sat", int'(sat_flag), 0);
`endif

        for (int s = 0; s < NBLK; s++)
            for (int i = 0; i < L; i++) begin
                tab_re[s][i] = int'($urandom_range(0, 511)) - 256;
                tab_im[s][i] = int'($urandom_range(0, 511)) - 256;
            end
        repeat (3) drive(1'b0, 1'b0, 0, 0, -1);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rst      = 1'b1;
                valid_in = 1'b0;
            end else begin
                drive_rand();
            end
        end
        repeat (5) drive(1'b0, 1'b0, 0, 0, -1);
        chk("queue_drained", q_due.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
